// File: rtl/rns_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rns_pkg
//  Purpose  : Shared constants and types for the RNS multiply-accumulate block
//  Revision : 1.0  initial release
// ============================================================================
package rns_pkg;

  // Number of residue channels and bits per packed residue
  localparam int RNS_CH = 4;
  localparam int RES_W  = 8;

  // Default moduli, pairwise coprime, one per channel
  localparam int DEF_B0 = 251;
  localparam int DEF_B1 = 241;
  localparam int DEF_B2 = 239;
  localparam int DEF_B3 = 233;

  // Packet-level controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rns_mac_channel.sv
`default_nettype none
// ============================================================================
//  Module   : rns_mac_channel
//  Purpose  : One residue lane: multiply, reduce mod MOD, accumulate mod MOD
//  Revision : 1.0  initial release
// ============================================================================
module rns_mac_channel
  import rns_pkg::*;
#(
  parameter int MOD = DEF_B0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  input  logic             clear,
  output logic [RES_W-1:0] acc
);

  localparam logic [2*RES_W-1:0] MOD_P = (2*RES_W)'(MOD);
  localparam logic [RES_W:0]     MOD_S = (RES_W+1)'(MOD);

  logic                 s1_valid;
  logic [2*RES_W-1:0]   s1_prod;
  logic                 s2_valid;
  logic [RES_W-1:0]     s2_res;
  logic [RES_W:0]       sum;
  logic [RES_W-1:0]     sum_mod;

  // Conditional subtract keeps the accumulator canonical; both addends are
  // already < MOD so a single correction is always enough
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, s2_res};
    sum_mod = (sum >= MOD_S) ? RES_W'(sum - MOD_S) : sum[RES_W-1:0];
  end

  // Three-stage pipeline: raw product, reduced residue, running sum.
  // Reduction of the full 16-bit product absorbs non-canonical inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s2_valid <= 1'b0;
      s2_res   <= '0;
      acc      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod <= {{RES_W{1'b0}}, a} * {{RES_W{1'b0}}, b};
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res <= RES_W'(s1_prod % MOD_P);
      end
      if (clear) begin
        acc <= '0;
      end else if (s2_valid) begin
        acc <= sum_mod;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rns_mac.sv
`default_nettype none
// ============================================================================
//  Module   : rns_mac
//  Purpose  : Packetised RNS dot-product engine, four independent residue
//             lanes with a valid/ready stream in and a held result out
//  Revision : 1.0  initial release
// ============================================================================
module rns_mac
  import rns_pkg::*;
#(
  parameter int b0 = DEF_B0,
  parameter int b1 = DEF_B1,
  parameter int b2 = DEF_B2,
  parameter int b3 = DEF_B3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RNS_CH*RES_W-1:0] in_a,
  input  logic [RNS_CH*RES_W-1:0] in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RNS_CH*RES_W-1:0] out_rns,
  output logic [15:0]             out_terms
);

  localparam int MODS [RNS_CH] = '{b0, b1, b2, b3};

  state_t                  state;
  state_t                  state_next;
  logic                    drain_cnt;
  logic [15:0]             terms;
  logic [RNS_CH*RES_W-1:0] acc_bus;
  logic                    accept;
  logic                    clear;

  assign accept = in_valid && in_ready;
  assign clear  = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DRAIN lasts two cycles so the last product reaches the
  // accumulator before the result is presented
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = in_last ? ST_DRAIN : ST_ACCUM;
      ST_ACCUM: if (accept && in_last) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_next = ST_HOLD;
      ST_HOLD:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State-decoded handshake outputs; ready is also held low during reset
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE, ST_ACCUM: in_ready  = rst_n;
      ST_HOLD:           out_valid = 1'b1;
      default: ;
    endcase
  end

  // Counts the cycles spent in DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= 1'b0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Saturating term counter, cleared when the result is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      terms <= '0;
    end else if (clear) begin
      terms <= '0;
    end else if (accept && (terms != 16'hFFFF)) begin
      terms <= terms + 16'd1;
    end
  end

  for (genvar i = 0; i < RNS_CH; i++) begin : g_ch
    rns_mac_channel #(
      .MOD (MODS[i])
    ) u_channel (
      .clk    (clk),
      .rst_n  (rst_n),
      .accept (accept),
      .a      (in_a[i*RES_W +: RES_W]),
      .b      (in_b[i*RES_W +: RES_W]),
      .clear  (clear),
      .acc    (acc_bus[i*RES_W +: RES_W])
    );
  end

  assign out_rns   = out_valid ? acc_bus : '0;
  assign out_terms = out_valid ? terms   : '0;

endmodule
`default_nettype wire

// File: tb/tb_rns_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rns_mac
//  Purpose  : Directed self-checking bench for rns_mac
//  Revision : 1.0  initial release
// ============================================================================
module tb_rns_mac;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rns;
  logic [15:0] out_terms;

  int checks = 0;
  int errors = 0;

  rns_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rns   (out_rns),
    .out_terms (out_terms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, confirm it is acceptable, let the edge take it
  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    chk("beat_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last beat was taken: two DRAIN cycles, then the
  // result in HOLD, then a handshake back to IDLE
  task automatic expect_result(input string tag, input logic [31:0] rns, input logic [15:0] nterms);
    chk({tag, "_drain1_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_drain1_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_drain1_rns"}, out_rns, 32'd0);
    tick();
    chk({tag, "_drain2_valid"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_rns"}, out_rns, rns);
    chk({tag, "_terms"}, {16'd0, out_terms}, {16'd0, nterms});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_post_rns"}, out_rns, 32'd0);
    chk({tag, "_post_terms"}, {16'd0, out_terms}, 32'd0);
    chk({tag, "_post_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic ready_ok;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_rns", out_rns, 32'd0);
    chk("rst_out_terms", {16'd0, out_terms}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Three-term packet
    beat(32'h0A0A0A0A, 32'h14141414, 1'b0);
    beat(32'h0A0A0A0A, 32'h14141414, 1'b0);
    beat(32'h0A0A0A0A, 32'h14141414, 1'b1);
    expect_result("three", 32'h867A7662, 16'd3);

    // Single-term packet with near-modulus residues
    beat(32'hFAFAFAFA, 32'hFAFAFAFA, 1'b1);
    expect_result("single", 32'h38795101, 16'd1);

    // Non-canonical residue in channel 3
    beat(32'hFF000000, 32'h01010101, 1'b1);
    expect_result("noncanon", 32'h16000000, 16'd1);

    // Back-pressure in HOLD with a pending input that must not be taken
    beat(32'h0A0A0A0A, 32'h14141414, 1'b0);
    beat(32'h0A0A0A0A, 32'h14141414, 1'b0);
    beat(32'h0A0A0A0A, 32'h14141414, 1'b1);
    tick();
    tick();
    in_valid = 1'b1;
    in_a     = 32'hFFFFFFFF;
    in_b     = 32'hFFFFFFFF;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_rns", out_rns, 32'h867A7662);
      chk("stall_terms", {16'd0, out_terms}, 32'd3);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_release_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_release_ready", {31'd0, in_ready}, 32'd1);

    // Reset part way through a packet, then replay
    beat(32'h0A0A0A0A, 32'h14141414, 1'b0);
    beat(32'h0A0A0A0A, 32'h14141414, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    beat(32'h0A0A0A0A, 32'h14141414, 1'b0);
    beat(32'h0A0A0A0A, 32'h14141414, 1'b0);
    beat(32'h0A0A0A0A, 32'h14141414, 1'b1);
    expect_result("replay", 32'h867A7662, 16'd3);

    // Idle gaps between beats
    beat(32'h0A0A0A0A, 32'h14141414, 1'b0);
    tick();
    tick();
    chk("gap_ready", {31'd0, in_ready}, 32'd1);
    beat(32'h0A0A0A0A, 32'h14141414, 1'b0);
    tick();
    beat(32'h0A0A0A0A, 32'h14141414, 1'b1);
    expect_result("gaps", 32'h867A7662, 16'd3);

    // 65537 unit products: counter saturates, residues are 65537 mod b_i
    ready_ok = 1'b1;
    in_a     = 32'h01010101;
    in_b     = 32'h01010101;
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int k = 0; k < 65537; k++) begin
      if (k == 65536) in_last = 1'b1;
      if (!in_ready) ready_ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("sat_ready_stream", {31'd0, ready_ok}, 32'd1);
    expect_result("sat", 32'h4033E21A, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rns_mac.md
RNS_MAC -- requirements
Module: rns_mac

Interface
REQ-001 Parameter b0, default 251, modulus of residue channel 0 (bits 7:0); legal range 2..255.
REQ-002 Parameter b1, default 241, modulus of channel 1 (bits 15:8); legal range 2..255.
REQ-003 Parameter b2, default 239, modulus of channel 2 (bits 23:16); legal range 2..255.
REQ-004 Parameter b3, default 233, modulus of channel 3 (bits 31:24); legal range 2..255.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 in_valid  input  1  operand pair on in_a/in_b/in_last is valid.
REQ-008 in_ready  output  1  block accepts an operand pair this cycle.
REQ-009 in_a  input  32  packed RNS operand A, 4 x 8-bit residues.
REQ-010 in_b  input  32  packed RNS operand B, same packing.
REQ-011 in_last  input  1  this beat is the final term of the dot product.
REQ-012 out_valid  output  1  result held on out_rns/out_terms.
REQ-013 out_ready  input  1  consumer takes the result this cycle.
REQ-014 out_rns  output  32  packed RNS dot product, canonical residues (< b_i).
REQ-015 out_terms  output  16  number of terms accumulated, saturating at 65535.

Function
REQ-016 Beat accepted when in_valid && in_ready on a rising clk edge.
REQ-017 Per channel i, result = sum over packet of (a_i * b_i) mod b_i; channels fully independent.
REQ-018 Stage 1 registers 16-bit product a_i*b_i; stage 2 registers product mod b_i; stage 3 accumulates: acc + r, subtract b_i if sum >= b_i (9-bit intermediate).
REQ-019 Non-canonical input residues (>= b_i, up to 255) produce the correct modular result without error signalling.
REQ-020 FSM states IDLE, ACCUM, DRAIN, HOLD; in_ready = 1 only in IDLE and ACCUM.
REQ-021 IDLE -> ACCUM on accepted beat with in_last=0; IDLE -> DRAIN on accepted beat with in_last=1 (single-term packet legal).
REQ-022 ACCUM -> DRAIN on accepted beat with in_last=1; ACCUM holds otherwise, including cycles with in_valid=0.
REQ-023 DRAIN lasts exactly 2 cycles, then HOLD; out_valid rises 3 cycles after the in_last beat is accepted.
REQ-024 HOLD: out_valid=1, out_rns and out_terms stable until out_ready=1; on that edge -> IDLE, accumulators and term counter cleared.
REQ-025 in_ready=0 throughout DRAIN and HOLD; no overlap between consecutive packets.
REQ-026 out_terms increments per accepted beat, clears on result handshake, saturates at 65535 without wrap.
REQ-027 out_valid asserted only in HOLD; out_rns/out_terms = 0 whenever out_valid=0.

Reset
REQ-028 rst_n low forces state IDLE, pipeline valid bits, accumulators and counter to 0 immediately, independent of clk.
REQ-029 Reset values: in_ready=0 while rst_n low, 1 in first cycle after release; out_valid=0, out_rns=0, out_terms=0.
REQ-030 Reset mid-packet discards partial sums; next packet result is unaffected by pre-reset beats.

Structure
REQ-031 Shared package rns_pkg holds RNS_CH=4, RES_W=8, default moduli, and the FSM state enum.
REQ-032 One sub-module rns_mac_channel (parameter MOD) implements the 3-stage multiply/reduce/accumulate for one residue, instantiated four times.
REQ-033 FSM, term counter and handshake live in rns_mac top level only.

Verification
REQ-034 Three beats a=0x0A0A0A0A, b=0x14141414, last on third -> out_rns=0x867A7662, out_terms=3, out_valid 3 cycles after last beat.
REQ-035 One beat a=b=0xFAFAFAFA, in_last=1 -> out_rns=0x38795101, out_terms=1.
REQ-036 a=0xFF000000, b=0x01010101, in_last=1 -> out_rns=0x16000000 (non-canonical 255 mod 233 = 22).
REQ-037 Hold out_ready=0 for 5 cycles in HOLD -> out_valid, out_rns stable, in_ready=0; release -> IDLE next cycle, in_ready=1.
REQ-038 Assert rst_n low after 2 beats of a packet, then replay REQ-034 -> identical 0x867A7662 result.
REQ-039 Gaps of in_valid=0 between beats of REQ-034 packet -> same result, out_terms=3.
